// File: rtl/dilithium_ctrl_pkg.sv
// rtl/dilithium_ctrl_pkg.sv - shared types and defaults for the Dilithium core control slice
package dilithium_ctrl_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  localparam int NUM_REQ_DEFAULT = 4;

endpackage

// File: rtl/core_start_arbiter_rr_pick.sv
// rtl/core_start_arbiter_rr_pick.sv - combinational round-robin picker, search starts after last owner
module rr_pick
  import dilithium_ctrl_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int SEL_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending_i,
  input  logic [SEL_W-1:0]   last_i,
  output logic               valid_o,
  output logic [SEL_W-1:0]   index_o
);

  logic             found;
  logic [SEL_W-1:0] cand;

  always_comb begin
    found = 1'b0;
    cand  = '0;
    index_o = '0;
    // k runs 1..NUM_REQ so the last owner is considered only after everyone else
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = SEL_W'((int'(last_i) + k) % NUM_REQ);
      if (!found && pending_i[cand]) begin
        found   = 1'b1;
        index_o = cand;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/core_start_arbiter.sv
// rtl/core_start_arbiter.sv - shares one Dilithium core between requesters with round-robin start/done handshake
// Optional BUSY watchdog with core abort: define CORE_ARB_TIMEOUT_EN.
module core_start_arbiter
  import dilithium_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = NUM_REQ_DEFAULT,
  parameter int SEL_W          = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_level,
  output logic               core_start,
  output logic [SEL_W-1:0]   core_sel,
  input  logic               core_done,
  output logic               core_abort,
  output logic [NUM_REQ-1:0] req_done,
  output logic [NUM_REQ-1:0] req_err,
  output logic               busy,
  output logic [NUM_REQ-1:0] pending
);

  arb_state_t         state_q;
  logic [NUM_REQ-1:0] prev_q, edge_q, pending_q, pending_d, grant_clr;
  logic [NUM_REQ-1:0] done_q;
  logic [SEL_W-1:0]   last_q, sel_q, pick_idx;
  logic               start_q, pick_valid, grant, done_ok;

  rr_pick #(.NUM_REQ(NUM_REQ), .SEL_W(SEL_W)) u_pick (
    .pending_i (pending_q),
    .last_i    (last_q),
    .valid_o   (pick_valid),
    .index_o   (pick_idx)
  );

  assign grant   = (state_q == ARB_IDLE) && pick_valid;
  // A done in the start cycle cannot belong to the job just launched
  assign done_ok = (state_q == ARB_BUSY) && core_done && !start_q;

  always_comb begin
    grant_clr = '0;
    if (grant) grant_clr[pick_idx] = 1'b1;
    pending_d = (pending_q & ~grant_clr) | edge_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= '0;
      edge_q    <= '0;
      pending_q <= '0;
    end else begin
      prev_q    <= req_level;
      edge_q    <= req_level & ~prev_q;
      pending_q <= pending_d;
    end
  end

`ifdef CORE_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]   cnt_q;
  logic               abort_q;
  logic [NUM_REQ-1:0] err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      start_q <= 1'b0;
      sel_q   <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
      done_q  <= '0;
`ifdef CORE_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      abort_q <= 1'b0;
      err_q   <= '0;
`endif
    end else begin
      start_q <= 1'b0;
      done_q  <= '0;
`ifdef CORE_ARB_TIMEOUT_EN
      abort_q <= 1'b0;
      err_q   <= '0;
`endif
      case (state_q)
        ARB_IDLE: begin
          if (pick_valid) begin
            state_q <= ARB_BUSY;
            start_q <= 1'b1;
            sel_q   <= pick_idx;
            last_q  <= pick_idx;
`ifdef CORE_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
          end
        end
        ARB_BUSY: begin
          if (done_ok) begin
            done_q[sel_q] <= 1'b1;
            state_q       <= ARB_IDLE;
          end
`ifdef CORE_ARB_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            abort_q       <= 1'b1;
            done_q[sel_q] <= 1'b1;
            err_q[sel_q]  <= 1'b1;
            state_q       <= ARB_IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign core_start = start_q;
  assign core_sel   = sel_q;
  assign req_done   = done_q;
  assign busy       = (state_q == ARB_BUSY);
  assign pending    = pending_q;
`ifdef CORE_ARB_TIMEOUT_EN
  assign core_abort = abort_q;
  assign req_err    = err_q;
`else
  assign core_abort = 1'b0;
  assign req_err    = '0;
`endif

endmodule
